pll_reset_seq: RTL
==================

# pll_reset_seq

Reset sequencer and clock-enable generator directly downstream of the PLL. It consumes the PLL output clock and its asynchronous lock flag, and holds the arcade core in reset until lock has been stable for a programmable time. It then produces deterministic-phase pixel and half-rate clock-enable pulses and re-enters reset whenever lock drops.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before leaving STABLE (≥2).
- HOLD_CYCLES, 16: cycles core_reset stays high while enables run (≥2).
- CEN_DIV, 6: clk cycles per cen_pix pulse (≥2).

Ports:
- clk, in, 1: PLL output clock; the only clock.
- reset, in, 1: synchronous, active-high.
- lock, in, 1: PLL lock flag, asynchronous to clk.
- soft_reset, in, 1: single-cycle request to re-run the HOLD phase.
- core_reset, out, 1: active-high reset to the core.
- ready, out, 1: high only in RUN.
- cen_pix, out, 1: one-cycle enable pulse, period CEN_DIV.
- cen_half, out, 1: one-cycle enable pulse, period 2*CEN_DIV.
- lock_lost, out, 1: sticky; lock dropped at least once while in RUN.
- relock_count, out, 4: saturating count of RUN→WAIT_LOCK events.

## Operation
- lock passes through a 2-FF synchronizer (lock_s). Only lock_s is used internally.
- Values while reset is high, and on the edge after it: state=WAIT_LOCK, core_reset=1, ready=0, cen_pix=0, cen_half=0, lock_lost=0, relock_count=0, synchronizer, stable_cnt, hold_cnt and div_cnt=0.
- WAIT_LOCK: stable_cnt=0. lock_s=1 → STABLE.
- STABLE: stable_cnt increments each cycle. lock_s=0 → WAIT_LOCK. stable_cnt==LOCK_STABLE_CYCLES-1 → HOLD; hold_cnt=0, div_cnt=0.
- HOLD: core_reset=1 and the divider runs. hold_cnt increments. lock_s=0 → WAIT_LOCK. hold_cnt==HOLD_CYCLES-1 → RUN.
- RUN: core_reset=0, ready=1.
  - lock_s=0 → WAIT_LOCK, set lock_lost, relock_count+1 (saturating at 15).
  - Else soft_reset=1 → HOLD with hold_cnt=0. div_cnt is not cleared, so enable phase is preserved.
- soft_reset is ignored outside RUN. If lock_s=0 and soft_reset arrive in the same RUN cycle, lock loss wins.
- Divider:
  - Active only in HOLD/RUN. In WAIT_LOCK/STABLE, div_cnt=0 and both enables are 0.
  - div_cnt counts 0..CEN_DIV-1 and wraps.
  - cen_pix=1 in every cycle where div_cnt==CEN_DIV-1.
  - A toggle flag (cleared with div_cnt) alternates on each cen_pix. cen_half=cen_pix AND flag, so it fires on the 2nd, 4th, … cen_pix.
- core_reset, ready, state and counters are registered. cen_pix and cen_half are decoded from registered counters, are glitch-free, and have no combinational path from any input.

## Timing
- Lock acquisition: take edge E1 as the first edge sampling lock=1.
  - lock_s=1 after E2; STABLE after E3.
  - HOLD after E(3+LOCK_STABLE_CYCLES); RUN after E(3+LOCK_STABLE_CYCLES+HOLD_CYCLES).
  - core_reset falls and ready rises at that edge.
- Lock glitches shorter than LOCK_STABLE_CYCLES in STABLE restart the count from WAIT_LOCK.
- Lock loss in RUN: lock=0 sampled at edge F1.
  - After F3, core_reset=1, ready=0, enables=0, lock_lost=1 and relock_count is updated.
  - So lock loss reaches core_reset within 3 edges.
- soft_reset sampled high in RUN at edge S: core_reset=1 after S. RUN resumes after S+HOLD_CYCLES. cen_pix cadence is unbroken.
- First cen_pix is HOLD cycle CEN_DIV-1, counting the HOLD entry cycle as 0. First cen_half is HOLD cycle 2*CEN_DIV-1.
- Synchronous reset mid-sequence (any state): all outputs take reset values at the next edge, including lock_lost and relock_count.

## Test plan
- Params 8/4/6, lock rises after reset → core_reset falls exactly 15 edges after first lock-sampling edge. cen_pix first high 5 cycles into HOLD, then every 6 cycles. cen_half every 12 cycles.
- Lock pulse of 5 cycles, then low, then steady high → no HOLD entry during the pulse; full 15-edge sequence from the second rise; lock_lost stays 0.
- In RUN, drop lock for 1 cycle → core_reset=1 and ready=0 within 3 edges, lock_lost=1, relock_count=1. RUN is re-reached 15 edges after lock returns.
- 17 lock-loss events from RUN → relock_count saturates at 15 and lock_lost stays 1.
- soft_reset pulse in RUN → core_reset high for exactly 4 cycles, cen_pix period stays 6 across the event, ready low for 4 cycles. The same soft_reset with simultaneous lock loss → WAIT_LOCK.
- Assert reset during HOLD and during RUN → next cycle all outputs at reset values, enables 0; sequence restarts cleanly on release.

Source files
------------

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock-qualified reset sequencer with pixel/half-rate clock enables
// Holds the core in reset until lock_s has been stable, then runs a phase-deterministic divider.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 16,
  parameter int CEN_DIV            = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  input  logic       soft_reset,
  output logic       core_reset,
  output logic       ready,
  output logic       cen_pix,
  output logic       cen_half,
  output logic       lock_lost,
  output logic [3:0] relock_count
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int DW = $clog2(CEN_DIV);

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CEN_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state;
  logic          lock_m;
  logic          lock_s;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] div_cnt;
  logic          half_flag;
  logic          div_active;

  // Enables decode purely from registered state so they cannot glitch on lock.
  assign div_active = (state == HOLD) || (state == RUN);
  assign cen_pix    = div_active && (div_cnt == DIV_LAST);
  assign cen_half   = cen_pix && half_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_LOCK;
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      stable_cnt   <= '0;
      hold_cnt     <= '0;
      div_cnt      <= '0;
      half_flag    <= 1'b0;
      core_reset   <= 1'b1;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= 4'd0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;

      // Divider free-runs through HOLD and RUN; transitions below override it.
      if (div_active) begin
        if (cen_pix) begin
          div_cnt   <= '0;
          half_flag <= ~half_flag;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      case (state)
        WAIT_LOCK: begin
          stable_cnt <= '0;
          div_cnt    <= '0;
          half_flag  <= 1'b0;
          core_reset <= 1'b1;
          ready      <= 1'b0;
          if (lock_s) begin
            state <= STABLE;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            div_cnt   <= '0;
            half_flag <= 1'b0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            div_cnt   <= '0;
            half_flag <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            ready      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN: begin
          // Lock loss takes priority over a coincident soft_reset.
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            div_cnt    <= '0;
            half_flag  <= 1'b0;
            lock_lost  <= 1'b1;
            if (relock_count != 4'hf) begin
              relock_count <= relock_count + 4'd1;
            end
          end else if (soft_reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            ready      <= 1'b0;
          end
        end

        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule
